// File: rtl/sdram_pkg.sv
// SDRAM command encodings and arbiter state codes, shared by the init/aref/wr/rd/arbiter blocks.
// Pure declarations: no latency and no flow control.
package sdram_pkg;

   // {CS_N, RAS_N, CAS_N, WE_N}
   localparam logic [3:0] CMD_NOP           = 4'b0111;
   localparam logic [3:0] CMD_PRECHARGE     = 4'b0010;
   localparam logic [3:0] CMD_AUTO_REFRESH  = 4'b0001;
   localparam logic [3:0] CMD_LOAD_MODE_REG = 4'b0000;
   localparam logic [3:0] CMD_ACTIVE        = 4'b0011;
   localparam logic [3:0] CMD_READ          = 4'b0101;
   localparam logic [3:0] CMD_WRITE         = 4'b0100;
   localparam logic [3:0] CMD_BURST_STOP    = 4'b0110;

   // Gray-style codes: every grant state is one bit away from ARBIT except READ,
   // since ARBIT has four neighbours and three bits only offer three.
   typedef enum logic [2:0] {
      ARB_IDLE  = 3'b000,
      ARB_ARBIT = 3'b001,
      ARB_AREF  = 3'b011,
      ARB_WRITE = 3'b101,
      ARB_READ  = 3'b111
   } arb_state_e;

   function automatic logic is_grant(arb_state_e s);
      return (s == ARB_AREF) || (s == ARB_WRITE) || (s == ARB_READ);
   endfunction

endpackage

// File: rtl/sdram_arbit_wdog.sv
// Grant watchdog: combinational timeout after TIMEOUT_MAX grant cycles; registered 1-cycle err pulse.
// No backpressure; a completion on the timeout cycle suppresses the error.
module sdram_arbit_wdog #(
   parameter int TIMEOUT_MAX = 2047
) (
   input  logic i_sysclk,
   input  logic i_sysrst_n,
   input  logic busy,
   input  logic done,
   output logic timeout,
   output logic arb_err
);

   localparam int CNT_W = $clog2(TIMEOUT_MAX + 1);
   // cnt holds (grant cycles elapsed - 1), so firing at LIMIT caps a grant at TIMEOUT_MAX cycles.
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_MAX - 1);

   logic [CNT_W-1:0] cnt;

   assign timeout = busy && (cnt == LIMIT);

   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         cnt     <= '0;
         arb_err <= 1'b0;
      end else begin
         arb_err <= timeout && !done;
         if (!busy || timeout || done) cnt <= '0;
         else                          cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus owner: init passthrough, then fixed-priority aref > wr > rd grants with a NOP gap.
// Zero-latency pin mux; requests are levels held until granted, grants end on *_end or watchdog.
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter int ADDR_W      = 13,
   parameter int BA_W        = 2,
   parameter int DQ_W        = 16,
   parameter int TIMEOUT_MAX = 2047
) (
   input  logic              i_sysclk,
   input  logic              i_sysrst_n,
   input  logic [3:0]        i_init_cmd,
   input  logic [BA_W-1:0]   i_init_ba,
   input  logic [ADDR_W-1:0] i_init_addr,
   input  logic              i_init_done,
   input  logic              i_aref_req,
   input  logic [3:0]        i_aref_cmd,
   input  logic [BA_W-1:0]   i_aref_ba,
   input  logic [ADDR_W-1:0] i_aref_addr,
   input  logic              i_aref_end,
   output logic              o_aref_en,
   input  logic              i_wr_req,
   input  logic [3:0]        i_wr_cmd,
   input  logic [BA_W-1:0]   i_wr_ba,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DQ_W-1:0]   i_wr_data,
   input  logic              i_wr_dq_oe,
   input  logic              i_wr_end,
   output logic              o_wr_en,
   input  logic              i_rd_req,
   input  logic [3:0]        i_rd_cmd,
   input  logic [BA_W-1:0]   i_rd_ba,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic              i_rd_end,
   output logic              o_rd_en,
   output logic              o_sdram_cke,
   output logic              o_sdram_cs_n,
   output logic              o_sdram_ras_n,
   output logic              o_sdram_cas_n,
   output logic              o_sdram_we_n,
   output logic [BA_W-1:0]   o_sdram_ba,
   output logic [ADDR_W-1:0] o_sdram_addr,
   output logic [DQ_W-1:0]   o_sdram_dq,
   output logic              o_sdram_dq_oe,
   output logic              o_arb_err
);

   arb_state_e state, state_nxt;
   logic       grant;
   logic       end_hit;
   logic       timeout;
   logic [3:0] cmd;

   assign grant = is_grant(state);

   // Only the granted requester's end counts; the others are ignored.
   always_comb begin
      end_hit = 1'b0;
      case (state)
         ARB_AREF:  end_hit = i_aref_end;
         ARB_WRITE: end_hit = i_wr_end;
         ARB_READ:  end_hit = i_rd_end;
         default:   end_hit = 1'b0;
      endcase
   end

   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) state <= ARB_IDLE;
      else             state <= state_nxt;
   end

   // Grant states always return through ARBIT, which guarantees the single NOP gap.
   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE:  if (i_init_done) state_nxt = ARB_ARBIT;
         ARB_ARBIT: begin
            if      (i_aref_req) state_nxt = ARB_AREF;
            else if (i_wr_req)   state_nxt = ARB_WRITE;
            else if (i_rd_req)   state_nxt = ARB_READ;
         end
         ARB_AREF, ARB_WRITE, ARB_READ: begin
            if (end_hit || timeout) state_nxt = ARB_ARBIT;
         end
         default:   state_nxt = ARB_IDLE;
      endcase
   end

   always_comb begin
      cmd          = CMD_NOP;
      o_sdram_ba   = '1;
      o_sdram_addr = '1;
      case (state)
         ARB_IDLE: begin
            cmd          = i_init_cmd;
            o_sdram_ba   = i_init_ba;
            o_sdram_addr = i_init_addr;
         end
         ARB_AREF: begin
            cmd          = i_aref_cmd;
            o_sdram_ba   = i_aref_ba;
            o_sdram_addr = i_aref_addr;
         end
         ARB_WRITE: begin
            cmd          = i_wr_cmd;
            o_sdram_ba   = i_wr_ba;
            o_sdram_addr = i_wr_addr;
         end
         ARB_READ: begin
            cmd          = i_rd_cmd;
            o_sdram_ba   = i_rd_ba;
            o_sdram_addr = i_rd_addr;
         end
         default: begin
            cmd          = CMD_NOP;
            o_sdram_ba   = '1;
            o_sdram_addr = '1;
         end
      endcase
   end

   assign {o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n} = cmd;

   assign o_aref_en     = (state == ARB_AREF);
   assign o_wr_en       = (state == ARB_WRITE);
   assign o_rd_en       = (state == ARB_READ);
   assign o_sdram_cke   = 1'b1;
   assign o_sdram_dq    = i_wr_data;
   assign o_sdram_dq_oe = (state == ARB_WRITE) && i_wr_dq_oe;

   sdram_arbit_wdog #(
      .TIMEOUT_MAX (TIMEOUT_MAX)
   ) u_wdog (
      .i_sysclk   (i_sysclk),
      .i_sysrst_n (i_sysrst_n),
      .busy       (grant),
      .done       (end_hit),
      .timeout    (timeout),
      .arb_err    (o_arb_err)
   );

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: stimulus pushes expected pin snapshots per cycle, a negedge monitor pops and compares.
module tb_sdram_arbit;
   import sdram_pkg::*;

   localparam int TMO = 20;

   typedef struct packed {
      logic        aref_en;
      logic        wr_en;
      logic        rd_en;
      logic        err;
      logic        cke;
      logic [3:0]  cmd;
      logic [1:0]  ba;
      logic [12:0] addr;
      logic        oe;
      logic [15:0] dq;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  init_cmd;
   logic [1:0]  init_ba;
   logic [12:0] init_addr;
   logic        init_done;
   logic        aref_req, aref_end, aref_en;
   logic [3:0]  aref_cmd;
   logic [1:0]  aref_ba;
   logic [12:0] aref_addr;
   logic        wr_req, wr_end, wr_en, wr_dq_oe;
   logic [3:0]  wr_cmd;
   logic [1:0]  wr_ba;
   logic [12:0] wr_addr;
   logic [15:0] wr_data;
   logic        rd_req, rd_end, rd_en;
   logic [3:0]  rd_cmd;
   logic [1:0]  rd_ba;
   logic [12:0] rd_addr;
   logic        cke, cs_n, ras_n, cas_n, we_n, dq_oe, arb_err;
   logic [1:0]  sd_ba;
   logic [12:0] sd_addr;
   logic [15:0] sd_dq;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   q_cyc[$];
   obs_t q_val[$];
   string q_name[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sdram_arbit #(
      .ADDR_W(13), .BA_W(2), .DQ_W(16), .TIMEOUT_MAX(TMO)
   ) dut (
      .i_sysclk(clk), .i_sysrst_n(rst_n),
      .i_init_cmd(init_cmd), .i_init_ba(init_ba), .i_init_addr(init_addr), .i_init_done(init_done),
      .i_aref_req(aref_req), .i_aref_cmd(aref_cmd), .i_aref_ba(aref_ba), .i_aref_addr(aref_addr),
      .i_aref_end(aref_end), .o_aref_en(aref_en),
      .i_wr_req(wr_req), .i_wr_cmd(wr_cmd), .i_wr_ba(wr_ba), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_wr_dq_oe(wr_dq_oe), .i_wr_end(wr_end), .o_wr_en(wr_en),
      .i_rd_req(rd_req), .i_rd_cmd(rd_cmd), .i_rd_ba(rd_ba), .i_rd_addr(rd_addr),
      .i_rd_end(rd_end), .o_rd_en(rd_en),
      .o_sdram_cke(cke), .o_sdram_cs_n(cs_n), .o_sdram_ras_n(ras_n), .o_sdram_cas_n(cas_n),
      .o_sdram_we_n(we_n), .o_sdram_ba(sd_ba), .o_sdram_addr(sd_addr),
      .o_sdram_dq(sd_dq), .o_sdram_dq_oe(dq_oe), .o_arb_err(arb_err)
   );

   always @(negedge clk) begin
      obs_t got;
      got = '{aref_en: aref_en, wr_en: wr_en, rd_en: rd_en, err: arb_err, cke: cke,
              cmd: {cs_n, ras_n, cas_n, we_n}, ba: sd_ba, addr: sd_addr, oe: dq_oe, dq: sd_dq};
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
         checks++;
         if (q_cyc[0] < cyc) begin
            errors++;
            $display("FAIL %s stale expectation cyc=%0d now=%0d", q_name[0], q_cyc[0], cyc);
         end else if (got !== q_val[0]) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", q_name[0], cyc, got, q_val[0]);
         end
         void'(q_cyc.pop_front());
         void'(q_val.pop_front());
         void'(q_name.pop_front());
      end
   end

   task automatic push(string nm, logic a, logic w, logic r, logic err,
                       logic [3:0] c, logic [1:0] b, logic [12:0] ad, logic oe);
      obs_t v;
      v = '{aref_en: a, wr_en: w, rd_en: r, err: err, cke: 1'b1,
            cmd: c, ba: b, addr: ad, oe: oe, dq: wr_data};
      q_cyc.push_back(cyc);
      q_val.push_back(v);
      q_name.push_back(nm);
   endtask

   task automatic e_idle(string nm);
      push(nm, 1'b0, 1'b0, 1'b0, 1'b0, init_cmd, init_ba, init_addr, 1'b0);
   endtask
   task automatic e_nop(string nm, logic err);
      push(nm, 1'b0, 1'b0, 1'b0, err, 4'b0111, 2'b11, 13'h1fff, 1'b0);
   endtask
   task automatic e_aref(string nm);
      push(nm, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'b10, 13'h0011, 1'b0);
   endtask
   task automatic e_wr(string nm, logic oe);
      push(nm, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 2'b01, 13'h0123, oe);
   endtask
   task automatic e_rd(string nm);
      push(nm, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 2'b10, 13'h0456, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; init_done = 1'b0;
      init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 13'h0400;
      aref_req = 1'b0; aref_end = 1'b0; aref_cmd = 4'b0001; aref_ba = 2'b10; aref_addr = 13'h0011;
      wr_req = 1'b0; wr_end = 1'b0; wr_dq_oe = 1'b0; wr_data = 16'hA5A5;
      wr_cmd = 4'b0100; wr_ba = 2'b01; wr_addr = 13'h0123;
      rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'b10; rd_addr = 13'h0456;

      // init passthrough and first arbitration cycle
      step(); e_idle("rst_idle");
      step(); e_idle("rst_idle2");
      step(); rst_n = 1'b1; e_idle("idle_after_rst");
      step(); e_idle("idle_wait");
      step(); init_done = 1'b1; e_idle("idle_done_cycle");
      step(); e_nop("arbit_nop", 1'b0);

      // priority order with one NOP between grants
      step(); aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1; e_nop("arbit_all_req", 1'b0);
      step(); aref_req = 1'b0; e_aref("aref_grant");
      step(); aref_end = 1'b1; e_aref("aref_end_cycle");
      step(); aref_end = 1'b0; e_nop("gap_after_aref", 1'b0);
      step(); wr_dq_oe = 1'b1; e_wr("wr_grant_oe", 1'b1);
      step(); rd_end = 1'b1; wr_data = 16'h5A5A; e_wr("wr_ignores_rd_end", 1'b1);
      step(); rd_end = 1'b0; wr_req = 1'b0; wr_end = 1'b1; wr_data = 16'hA5A5; e_wr("wr_end_cycle", 1'b1);
      step(); wr_end = 1'b0; e_nop("gap_after_wr_oe_masked", 1'b0);
      step(); rd_req = 1'b0; e_rd("rd_grant_oe_masked");
      step(); rd_end = 1'b1; e_rd("rd_end_cycle");
      step(); rd_end = 1'b0; wr_dq_oe = 1'b0; e_nop("gap_after_rd", 1'b0);
      step(); e_nop("arbit_no_req", 1'b0);

      // watchdog release
      step(); wr_req = 1'b1; e_nop("arbit_wr_req", 1'b0);
      for (int i = 1; i <= TMO; i++) begin
         step(); wr_req = 1'b0; e_wr("wdog_hold", 1'b0);
      end
      step(); e_nop("wdog_err", 1'b1);
      step(); e_nop("wdog_err_clear", 1'b0);

      // end on the timeout cycle wins
      step(); wr_req = 1'b1; e_nop("arbit_wr_req2", 1'b0);
      for (int i = 1; i <= TMO; i++) begin
         step(); wr_req = 1'b0; wr_end = (i == TMO); e_wr("wdog_hold2", 1'b0);
      end
      step(); wr_end = 1'b0; e_nop("end_beats_wdog", 1'b0);
      step(); e_nop("no_late_err", 1'b0);

      // async reset mid-read
      step(); rd_req = 1'b1; e_nop("arbit_rd_req", 1'b0);
      step(); rd_req = 1'b0; e_rd("rd_before_rst");
      step(); rst_n = 1'b0; init_done = 1'b0; e_idle("rst_mid_read");
      step(); init_cmd = 4'b0000; init_addr = 13'h0033; e_idle("rst_held_new_init");
      step(); rst_n = 1'b1; e_idle("idle_after_rerst");
      step(); init_cmd = 4'b0001; e_idle("idle_follow_init");
      step(); init_done = 1'b1; e_idle("idle_done_cycle2");
      step(); e_nop("arbit_after_rerst", 1'b0);
      step();
      @(negedge clk);
      #1;

      checks++;
      if (q_cyc.size() != 0) begin
         errors++;
         $display("FAIL queue_drain left=%0d required=0", q_cyc.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
